uart_rx: RTL and testbench

8x-oversampling UART receiver. It consumes the `baud_tick` strobe from the baud generator, which pulses once every 100 MHz / (BAUD*8) clocks. It deserialises 8N1 frames from the asynchronous `rx` pin into a byte with a one-cycle `rx_done` strobe. It sits between the pad and the RX FIFO, and its `rx_done` drives the FIFO push.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Pure declarations; no latency, no flow control.
// Defaults are reused by the baud generator and the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 8;
  localparam int UART_DATA_BITS  = 8;

  localparam logic [2:0] RX_IDLE_ENC   = 3'd0;
  localparam logic [2:0] RX_START_ENC  = 3'd1;
  localparam logic [2:0] RX_DATA_ENC   = 3'd2;
  localparam logic [2:0] RX_PARITY_ENC = 3'd3;
  localparam logic [2:0] RX_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = RX_IDLE_ENC,
    START  = RX_START_ENC,
    DATA   = RX_DATA_ENC,
    PARITY = RX_PARITY_ENC,
    STOP   = RX_STOP_ENC
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pad plus a history flop for falling-edge detect.
// Latency: rx_s lags rx by 2 clk; fall_edge is combinational from rx_s and its history.
// No backpressure; flops reset to 1 so a held-idle line produces no edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic sync1;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      prev  <= rx_s;
    end
  end

  assign fall_edge = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver; UART_RX_PARITY_EN adds an even-parity bit and parity_err.
// Latency: rx_done/frame_err/rx_data update one clk after the baud_tick that samples the stop bit.
// No backpressure: the consumer must accept every rx_done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;
  logic fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  rx_state_t              state_q, state_nxt;
  logic [TW-1:0]          tick_cnt, tick_nxt;
  logic [BW-1:0]          bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]   shift_q, shift_nxt;
  logic [DATA_BITS-1:0]   data_nxt;
  logic                   done_nxt;
  logic                   ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_nxt;
  logic                   perr_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_q   <= shift_nxt;
      rx_data   <= data_nxt;
      rx_done   <= done_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_nxt;
      parity_err <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    data_nxt  = rx_data;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_q;
    perr_nxt  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // prev/now edge requirement means a held-low break cannot retrigger
        if (fall_edge) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt == TICK_HALF) begin
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == TICK_LAST) begin
            shift_nxt = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_nxt  = '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == TICK_LAST) begin
            par_nxt   = rx_s;
            tick_nxt  = '0;
            state_nxt = STOP;
          end
        end
      end
`endif
      STOP: begin
        // leaving at mid stop bit leaves half a bit to catch a back-to-back start edge
        if (baud_tick) begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == TICK_LAST) begin
            if (rx_s) begin
              data_nxt = shift_q;
              done_nxt = 1'b1;
            end else begin
              ferr_nxt = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_nxt = ^{shift_q, par_q};
`endif
            tick_nxt  = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed-frame bench for uart_rx with a queued scoreboard and an independent strobe monitor.
// Define UART_RX_PARITY_EN for both RTL and bench to exercise the parity variant.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] data, input logic perr);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.perr   = perr;
    exp_q.push_back(e);
  endtask

  // 32-clk bit period: baud_tick every 4 clks, 8 ticks per bit
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input int abort_bit);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        repeat (16) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      repeat (32) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_bit;
      repeat (32) @(negedge clk);
    end
    rx = stop_bit;
    repeat (32) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  // strobe monitor: every rx_done/frame_err cycle must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (rx_done || frame_err)) begin
        check("strobe_exclusive", 32'(rx_done & frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: rx_done=%0b frame_err=%0b rx_data=0x%0h, expected no strobe",
                   rx_done, frame_err, rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind_frame_err", 32'(frame_err), 32'(mon_e.is_err));
          check("strobe_rx_data", 32'(rx_data), 32'(mon_e.data));
`ifdef UART_RX_PARITY_EN
          check("strobe_parity_err", 32'(parity_err), 32'(mon_e.perr));
`endif
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // single frame with busy profile
    push_exp(1'b0, 8'hA5, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      begin
        repeat (8) @(negedge clk);
        check("busy_after_start", 32'(rx_busy), 32'h1);
        repeat (280) @(negedge clk);
        check("busy_before_stop_sample", 32'(rx_busy), 32'h1);
      end
    join
    check("busy_after_stop", 32'(rx_busy), 32'h0);
    check("single_rx_data", 32'(rx_data), 32'hA5);
    repeat (40) @(negedge clk);

    // back-to-back frames
    push_exp(1'b0, 8'h00, 1'b0);
    push_exp(1'b0, 8'hFF, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    repeat (8) @(negedge clk);
    check("b2b_rx_data", 32'(rx_data), 32'hFF);
    repeat (40) @(negedge clk);

    // false start: 2 ticks low
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check("false_start_busy", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    check("false_start_idle", 32'(rx_busy), 32'h0);
    repeat (64) @(negedge clk);

    // framing error keeps old data, then a good frame
    push_exp(1'b1, 8'hFF, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (64) @(negedge clk);
    check("ferr_rx_data_held", 32'(rx_data), 32'hFF);
    push_exp(1'b0, 8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    repeat (40) @(negedge clk);

    // reset during bit 3 of 0xF0
    send_frame(8'hF0, 1'b1, 1'b0, 3);
    @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_busy", 32'(rx_busy), 32'h0);
    repeat (64) @(negedge clk);
    push_exp(1'b0, 8'h81, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    repeat (8) @(negedge clk);
    check("after_reset_rx_data", 32'(rx_data), 32'h81);
    repeat (40) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    push_exp(1'b0, 8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    repeat (40) @(negedge clk);
    push_exp(1'b0, 8'h07, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, -1);
    repeat (40) @(negedge clk);
`endif

    for (int w = 0; w < 400 && exp_q.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
